// File: rtl/wifi_tx_symbol_mapper.sv
// Maps the interleaver's serial bit stream to BPSK (SIGNAL symbol) and Gray-coded QPSK points,
// one registered I/Q point per subcarrier with symbol framing.
module wifi_tx_symbol_mapper #(
    parameter int NSD      = 48,
    parameter int SIG_BITS = 48,
    parameter int IQ_W     = 8,
    parameter int AMP_BPSK = 127,
    parameter int AMP_QPSK = 91
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   valid_in,
    input  logic                   data_in,
    input  logic                   finished_in,
    output logic                   valid_out,
    output logic signed [IQ_W-1:0] i_out,
    output logic signed [IQ_W-1:0] q_out,
    output logic [5:0]             sc_index,
    output logic                   sym_start,
    output logic                   sym_end,
    output logic                   signal_sym,
    output logic [15:0]            sym_count,
    output logic                   frame_err
);

    localparam int BitW = $clog2(SIG_BITS + 1);
    localparam logic signed [IQ_W-1:0] BpskP = IQ_W'(AMP_BPSK);
    localparam logic signed [IQ_W-1:0] BpskN = IQ_W'(-AMP_BPSK);
    localparam logic signed [IQ_W-1:0] QpskP = IQ_W'(AMP_QPSK);
    localparam logic signed [IQ_W-1:0] QpskN = IQ_W'(-AMP_QPSK);

    typedef enum logic [1:0] {StIdle, StSig, StData} state_e;

    state_e                 state_q, state_d;
    logic [BitW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                   half_q, half_d;
    logic                   first_q, first_d;
    logic [5:0]             sc_q, sc_d;
    logic                   first_sym_q, first_sym_d;
    logic                   valid_q, valid_d;
    logic signed [IQ_W-1:0] i_q, i_d, q_q, q_d;
    logic [5:0]             sc_idx_q, sc_idx_d;
    logic                   start_q, start_d, end_q, end_d;
    logic                   sig_q, sig_d;
    logic [15:0]            sym_cnt_q, sym_cnt_d;
    logic                   err_q, err_d;
    logic                   emit;
    logic signed [IQ_W-1:0] emit_i, emit_q;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        half_d      = half_q;
        first_d     = first_q;
        sc_d        = sc_q;
        first_sym_d = first_sym_q;
        valid_d     = 1'b0;
        i_d         = i_q;
        q_d         = q_q;
        sc_idx_d    = sc_idx_q;
        start_d     = 1'b0;
        end_d       = 1'b0;
        sig_d       = sig_q;
        sym_cnt_d   = sym_cnt_q;
        err_d       = err_q;
        emit        = 1'b0;
        emit_i      = '0;
        emit_q      = '0;

        if (enable) begin
            if (valid_in) begin
                // The first accepted bit opens a new frame and is itself SIGNAL bit 0.
                if (state_q == StIdle) begin
                    err_d       = 1'b0;
                    sym_cnt_d   = '0;
                    sc_d        = '0;
                    first_sym_d = 1'b1;
                    bit_cnt_d   = '0;
                    half_d      = 1'b0;
                end
                if (state_q != StData) begin
                    emit   = 1'b1;
                    emit_i = data_in ? BpskP : BpskN;
                    if (bit_cnt_d == BitW'(SIG_BITS - 1)) begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                    end else begin
                        state_d   = StSig;
                        bit_cnt_d = bit_cnt_d + BitW'(1);
                    end
                end else if (!half_q) begin
                    half_d  = 1'b1;
                    first_d = data_in;
                end else begin
                    half_d = 1'b0;
                    emit   = 1'b1;
                    emit_i = first_q ? QpskP : QpskN;
                    emit_q = data_in ? QpskP : QpskN;
                end
            end else if (finished_in && (state_q != StIdle)) begin
                state_d   = StIdle;
                if (half_q || (sc_q != '0)) err_d = 1'b1;
                half_d    = 1'b0;
                sc_d      = '0;
                bit_cnt_d = '0;
            end
        end

        if (emit) begin
            valid_d  = 1'b1;
            i_d      = emit_i;
            q_d      = emit_q;
            sc_idx_d = sc_d;
            start_d  = (sc_d == '0);
            sig_d    = first_sym_d;
            if (sc_d == 6'(NSD - 1)) begin
                end_d       = 1'b1;
                sym_cnt_d   = sym_cnt_d + 16'd1;
                sc_d        = '0;
                first_sym_d = 1'b0;
            end else begin
                sc_d = sc_d + 6'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            half_q      <= 1'b0;
            first_q     <= 1'b0;
            sc_q        <= '0;
            first_sym_q <= 1'b0;
            valid_q     <= 1'b0;
            i_q         <= '0;
            q_q         <= '0;
            sc_idx_q    <= '0;
            start_q     <= 1'b0;
            end_q       <= 1'b0;
            sig_q       <= 1'b0;
            sym_cnt_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            half_q      <= half_d;
            first_q     <= first_d;
            sc_q        <= sc_d;
            first_sym_q <= first_sym_d;
            valid_q     <= valid_d;
            i_q         <= i_d;
            q_q         <= q_d;
            sc_idx_q    <= sc_idx_d;
            start_q     <= start_d;
            end_q       <= end_d;
            sig_q       <= sig_d;
            sym_cnt_q   <= sym_cnt_d;
            err_q       <= err_d;
        end
    end

    assign valid_out  = valid_q;
    assign i_out      = i_q;
    assign q_out      = q_q;
    assign sc_index   = sc_idx_q;
    assign sym_start  = start_q;
    assign sym_end    = end_q;
    assign signal_sym = sig_q;
    assign sym_count  = sym_cnt_q;
    assign frame_err  = err_q;

endmodule
